// File: rtl/alu_result_path.sv
// Execute/writeback slice of the multicycle RV32I core: combinational ALU with
// status flags, the ALUOut register, and the result-select multiplexer.

module alu_result_path_alu (
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        negative,
    output logic        overflow,
    output logic        less_than
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLTU = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001,
        OP_PASS = 4'b1010
    } alu_op_e;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        ovf_add;
    logic        ovf_sub;

    assign sum   = src_a + src_b;
    assign diff  = src_a - src_b;
    assign shamt = src_b[4:0];

    // Direct comparators rather than diff[31], so the result stays correct
    // when the subtraction overflows.
    assign lt_s = $signed(src_a) < $signed(src_b);
    assign lt_u = src_a < src_b;

    assign ovf_add = (src_a[31] == src_b[31]) && (sum[31]  != src_a[31]);
    assign ovf_sub = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);

    always_comb begin
        alu_result = 32'h0;
        overflow   = 1'b0;
        case (alu_control)
            OP_ADD: begin
                alu_result = sum;
                overflow   = ovf_add;
            end
            OP_SUB: begin
                alu_result = diff;
                overflow   = ovf_sub;
            end
            OP_AND:  alu_result = src_a & src_b;
            OP_OR:   alu_result = src_a | src_b;
            OP_XOR:  alu_result = src_a ^ src_b;
            OP_SLT:  alu_result = {31'b0, lt_s};
            OP_SLTU: alu_result = {31'b0, lt_u};
            OP_SLL:  alu_result = src_a << shamt;
            OP_SRL:  alu_result = src_a >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
            OP_PASS: alu_result = src_b;
            default: alu_result = 32'h0;
        endcase
    end

    assign zero      = (alu_result == 32'h0);
    assign negative  = alu_result[31];
    assign less_than = lt_s;
endmodule

module alu_result_path (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  alu_control,
    input  logic [1:0]  result_src,
    input  logic [31:0] data_reg_out,
    output logic [31:0] alu_result,
    output logic [31:0] alu_out,
    output logic [31:0] alu_mux_out,
    output logic        zero,
    output logic        negative,
    output logic        overflow,
    output logic        less_than
);
    logic [31:0] alu_out_q;
    logic [31:0] alu_out_d;

    alu_result_path_alu u_alu (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
        .less_than   (less_than)
    );

    assign alu_out_d = alu_result;

    // Unconditional capture: the control FSM relies on ALUOut always holding
    // the previous state's result (e.g. PC+4 for the fetch update).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) alu_out_q <= 32'h0;
        else        alu_out_q <= alu_out_d;
    end

    assign alu_out = alu_out_q;

    always_comb begin
        alu_mux_out = 32'h0;
        case (result_src)
            2'b00:   alu_mux_out = alu_out_q;
            2'b01:   alu_mux_out = data_reg_out;
            2'b10:   alu_mux_out = alu_result;
            default: alu_mux_out = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_alu_result_path.sv
// Directed bench for alu_result_path: reset, ALU ops/flags, result mux and
// ALUOut latency, checked with immediate assertions.

module tb_alu_result_path;
    logic        clk;
    logic        reset;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  alu_control;
    logic [1:0]  result_src;
    logic [31:0] data_reg_out;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [31:0] alu_mux_out;
    logic        zero;
    logic        negative;
    logic        overflow;
    logic        less_than;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_path dut (
        .clk          (clk),
        .reset        (reset),
        .src_a        (src_a),
        .src_b        (src_b),
        .alu_control  (alu_control),
        .result_src   (result_src),
        .data_reg_out (data_reg_out),
        .alu_result   (alu_result),
        .alu_out      (alu_out),
        .alu_mux_out  (alu_mux_out),
        .zero         (zero),
        .negative     (negative),
        .overflow     (overflow),
        .less_than    (less_than)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        src_a       = a;
        src_b       = b;
        alu_control = op;
        #1;
    endtask

    logic [3:0]  b2b_op  [4];
    logic [31:0] b2b_exp [4];

    initial begin
        b2b_op[0] = 4'b0000; b2b_exp[0] = 32'h00E100E0;
        b2b_op[1] = 4'b0001; b2b_exp[1] = 32'hE100E100;
        b2b_op[2] = 4'b0100; b2b_exp[2] = 32'hFF00FF00;
        b2b_op[3] = 4'b0011; b2b_exp[3] = 32'hFFF0FFF0;

        // Reset with live combinational inputs
        reset        = 1'b0;
        result_src   = 2'b10;
        data_reg_out = 32'h0;
        src_a        = 32'd5;
        src_b        = 32'd7;
        alu_control  = 4'b0000;
        #2;
        check("rst_alu_out_noclk", alu_out, 32'h0);
        check("rst_alu_result", alu_result, 32'd12);
        check("rst_mux_sel10", alu_mux_out, 32'd12);
        @(posedge clk); #1;
        check("rst_alu_out_held", alu_out, 32'h0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst_first_capture", alu_out, 32'd12);

        // ADD/SUB flags
        @(negedge clk);
        drive(32'h7FFFFFFF, 32'h1, 4'b0000);
        check("add_ovf_result", alu_result, 32'h80000000);
        check("add_ovf_overflow", {31'b0, overflow}, 32'd1);
        check("add_ovf_negative", {31'b0, negative}, 32'd1);
        check("add_ovf_zero", {31'b0, zero}, 32'd0);
        drive(32'd5, 32'd5, 4'b0001);
        check("sub_zero_result", alu_result, 32'h0);
        check("sub_zero_zero", {31'b0, zero}, 32'd1);
        check("sub_zero_overflow", {31'b0, overflow}, 32'd0);
        drive(32'h80000000, 32'h1, 4'b0001);
        check("sub_ovf_result", alu_result, 32'h7FFFFFFF);
        check("sub_ovf_overflow", {31'b0, overflow}, 32'd1);
        check("sub_ovf_less_than", {31'b0, less_than}, 32'd1);

        // Logic ops
        drive(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0010);
        check("and", alu_result, 32'h00F000F0);
        drive(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011);
        check("or", alu_result, 32'hFFF0FFF0);
        check("or_overflow_clear", {31'b0, overflow}, 32'd0);
        drive(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100);
        check("xor", alu_result, 32'hFF00FF00);

        // Shifts: only src_b[4:0] counts
        drive(32'h80000000, 32'h24, 4'b0111);
        check("sll", alu_result, 32'h0);
        check("sll_zero", {31'b0, zero}, 32'd1);
        drive(32'h80000000, 32'h24, 4'b1000);
        check("srl", alu_result, 32'h08000000);
        drive(32'h80000000, 32'h24, 4'b1001);
        check("sra", alu_result, 32'hF8000000);
        check("sra_negative", {31'b0, negative}, 32'd1);

        // Compares, PASS_B, undefined code
        drive(32'hFFFFFFFF, 32'h1, 4'b0101);
        check("slt", alu_result, 32'd1);
        check("less_than", {31'b0, less_than}, 32'd1);
        drive(32'hFFFFFFFF, 32'h1, 4'b0110);
        check("sltu", alu_result, 32'd0);
        check("less_than_sltu", {31'b0, less_than}, 32'd1);
        drive(32'hFFFFFFFF, 32'h12345000, 4'b1010);
        check("pass_b", alu_result, 32'h12345000);
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111);
        check("undef_result", alu_result, 32'h0);
        check("undef_zero", {31'b0, zero}, 32'd1);
        check("undef_negative", {31'b0, negative}, 32'd0);

        // Mux and ALUOut latency
        @(negedge clk);
        drive(32'h80, 32'h80, 4'b0000);
        check("cyc0_result", alu_result, 32'h100);
        @(negedge clk);
        data_reg_out = 32'hDEAD;
        drive(32'h100, 32'h100, 4'b0000);
        result_src = 2'b00; #1;
        check("mux_sel00", alu_mux_out, 32'h100);
        result_src = 2'b10; #1;
        check("mux_sel10", alu_mux_out, 32'h200);
        result_src = 2'b01; #1;
        check("mux_sel01", alu_mux_out, 32'hDEAD);
        result_src = 2'b11; #1;
        check("mux_sel11", alu_mux_out, 32'h0);

        // Back-to-back op changes
        result_src = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(32'hF0F0F0F0, 32'h0FF00FF0, b2b_op[k]);
            check($sformatf("b2b_result_%0d", k), alu_result, b2b_exp[k]);
            @(posedge clk); #1;
            check($sformatf("b2b_alu_out_%0d", k), alu_out, b2b_exp[k]);
            check($sformatf("b2b_mux_%0d", k), alu_mux_out, b2b_exp[k]);
        end

        // Asynchronous reset mid-cycle
        @(negedge clk);
        reset = 1'b0; #1;
        check("async_reset", alu_out, 32'h0);
        check("async_reset_comb", alu_result, 32'hFFF0FFF0);
        @(posedge clk); #1;
        check("async_reset_hold", alu_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_result_path.md
# alu_result_path

Execute/writeback datapath slice of the multicycle RV32I core: a combinational 32-bit ALU with status flags, the ALUOut holding register, and the result-select multiplexer. The multiplexer output drives the PC next-value, register-file write data and the AUIPC feedback path. The slice sits between the SrcA/SrcB multiplexers and the PC/register file, and is steered by the control unit through `alu_control` and `result_src`.

## Interface
Parameters: none (datapath fixed at 32 bits).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears ALUOut register.
- src_a  in  32  ALU operand A (from SrcA mux).
- src_b  in  32  ALU operand B (from SrcB mux).
- alu_control  in  4  operation select (encoding below).
- result_src  in  2  result mux select.
- data_reg_out  in  32  load data after word-size extension.
- alu_result  out  32  combinational ALU result.
- alu_out  out  32  registered ALU result (ALUOut).
- alu_mux_out  out  32  selected result.
- zero  out  1  alu_result == 0.
- negative  out  1  alu_result[31].
- overflow  out  1  signed overflow of ADD/SUB; 0 for other ops.
- less_than  out  1  signed src_a < src_b, independent of alu_control.

## Operation
- alu_control encoding:
  - 0000 ADD a+b
  - 0001 SUB a−b
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLT (signed a<b → 1 else 0)
  - 0110 SLTU (unsigned)
  - 0111 SLL a<<b[4:0]
  - 1000 SRL logical
  - 1001 SRA arithmetic
  - 1010 PASS_B (result = b, used for LUI)
  - 1011–1111 result 32'h0
- Arithmetic is modulo 2^32; carry-out is discarded. Shift amount uses only src_b[4:0]; src_b[31:5] is ignored.
- overflow:
  - ADD: a[31]==b[31] && r[31]!=a[31].
  - SUB: a[31]!=b[31] && r[31]!=a[31].
- zero and negative derive from alu_result for every op, including undefined codes (undefined code → zero=1, negative=0).
- less_than is a dedicated signed comparator. It is correct even when SUB overflows (e.g. a=0x80000000, b=1 → 1).
- ALU is purely combinational; it has no clock dependency.
- aluout register: alu_out ← alu_result on every rising clk, with no enable.
- Result mux:
  - 00 → alu_out
  - 01 → data_reg_out
  - 10 → alu_result
  - 11 → 32'h0

## Timing
- reset low: alu_out = 32'h0 immediately, independent of clk. It holds 0 while reset is low. First capture happens at the first rising edge after reset goes high.
- Combinational outputs (alu_result, flags, alu_mux_out for selects 01/10/11) have zero-cycle latency and are valid within the same cycle as their inputs.
- alu_out has one-cycle latency: it holds the alu_result present before edge N from edge N until edge N+1.
- With result_src=00, alu_mux_out reflects the previous cycle's ALU result. This lets the PC update with PC+4 computed one state earlier.
- Simultaneous reset assertion and clk edge: reset wins, alu_out = 0.
- All outputs are defined during reset. Combinational outputs continue to follow their inputs while reset is low.

## Test plan
- Reset:
  - Drive reset=0 with src_a=5, src_b=7, alu_control=0000.
  - alu_out=0 with no clock edge required.
  - alu_result=12 combinationally.
  - After reset=1 and one clk edge, alu_out=12.
- ADD/SUB flags:
  - 0x7FFFFFFF+1 → 0x80000000, overflow=1, negative=1, zero=0.
  - 5−5 → 0, zero=1, overflow=0.
  - 0x80000000−1 → 0x7FFFFFFF, overflow=1, less_than=1.
- Logic/shift:
  - a=0xF0F0F0F0, b=0x0FF00FF0:
    - AND=0x00F000F0.
    - OR=0xFFF0FFF0.
    - XOR=0xFF00FF00.
  - a=0x80000000, b=0x24 (shamt 4):
    - SLL=0.
    - SRL=0x08000000.
    - SRA=0xF8000000.
- Compare ops (a=0xFFFFFFFF, b=1):
  - SLT → 1.
  - SLTU → 0.
  - less_than=1.
  - PASS_B (b=0x12345000) → 0x12345000.
  - Code 1111 → 0, zero=1.
- Mux/latency:
  - Cycle 0: ALU result 0x100.
  - Cycle 1: ALU result 0x200, data_reg_out=0xDEAD.
  - In cycle 1:
    - result_src=00 → 0x100.
    - result_src=10 → 0x200.
    - result_src=01 → 0xDEAD.
    - result_src=11 → 0.
- Back-to-back: change alu_control every cycle for 4 cycles. alu_out must equal the prior cycle's alu_result each cycle.
